rr_logb_flow_ctrl: RTL

// - Flow controller for the packed logging bus between the merge-tree output and the trace-buffer writer.
// - Tracks, in bits, the occupancy of the writer's staging buffer and schedules fixed-width drain beats.
// - Drives logb_almful_hi/lo with a round-trip-latency safety margin and hysteresis.
// - Sequences explicit flushes: block inputs, wait out in-flight data, drain the partial beat, signal done.

---
 rtl/rr_logb_flow_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rr_logb_flow_ctrl.sv
// Flow controller for the packed logging bus: tracks staging-buffer occupancy in bits,
// offers fixed-width drain beats, drives almful with hysteresis and sequences flushes.
`timescale 1ns/1ps
module rr_logb_flow_ctrl #(
    parameter  int unsigned BUF_BITS   = 32768,
    parameter  int unsigned MAX_LEN    = 1024,
    parameter  int unsigned BEAT_WIDTH = 512,
    parameter  int unsigned PIPE_LAT   = 4,
    parameter  int unsigned HYST_BITS  = 512,
    parameter  int unsigned LO_EXTRA   = 2048,
    localparam int unsigned OW = $clog2(MAX_LEN + 1),
    localparam int unsigned BW = $clog2(BEAT_WIDTH + 1),
    localparam int unsigned CW = $clog2(BUF_BITS + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          plogb_any_valid,
    input  logic [OW-1:0] plogb_len,
    output logic          drain_req,
    output logic [BW-1:0] drain_len,
    input  logic          drain_ack,
    output logic          logb_almful_hi,
    output logic          logb_almful_lo,
    input  logic          flush_req,
    output logic          flush_busy,
    output logic          flush_done,
    output logic [CW-1:0] occupancy,
    output logic          overflow_err
);

    localparam int unsigned HI_TH    = (2 * PIPE_LAT + 2) * MAX_LEN;
    localparam int unsigned LO_TH    = HI_TH + LO_EXTRA;
    localparam int unsigned WAIT_CNT = 2 * PIPE_LAT + 1;
    localparam int unsigned CTW      = $clog2(WAIT_CNT + 1);

    localparam logic [CW:0] BUF_W  = (CW+1)'(BUF_BITS);
    localparam logic [CW:0] HI_SET = (CW+1)'(HI_TH);
    localparam logic [CW:0] HI_CLR = (CW+1)'(HI_TH + HYST_BITS);
    localparam logic [CW:0] LO_SET = (CW+1)'(LO_TH);
    localparam logic [CW:0] LO_CLR = (CW+1)'(LO_TH + HYST_BITS);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FL_WAIT  = 2'd1,
        FL_DRAIN = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t         state;
    logic [CTW-1:0] wait_cnt;
    logic           hi_thr;
    logic           lo_thr;

    logic [CW:0]    add_w;
    logic [CW:0]    pop_w;
    logic [CW:0]    sum_w;
    logic [CW:0]    free_w;
    logic [CW-1:0]  occ_nx;
    logic           ovf_w;
    logic           hi_thr_nx;
    logic           lo_thr_nx;
    logic           busy_nx;

    // Beat offer is combinational from registers only; a partial beat is offered only while draining a flush.
    assign drain_req = (occupancy >= CW'(BEAT_WIDTH)) || ((state == FL_DRAIN) && (occupancy != '0));
    assign drain_len = (occupancy >= CW'(BEAT_WIDTH)) ? BW'(BEAT_WIDTH) : BW'(occupancy);

    always_comb begin
        add_w     = '0;
        pop_w     = '0;
        hi_thr_nx = hi_thr;
        lo_thr_nx = lo_thr;
        if (plogb_any_valid) begin
            add_w = (CW+1)'(plogb_len);
        end
        if (drain_req && drain_ack) begin
            pop_w = (CW+1)'(drain_len);
        end
        sum_w  = (CW+1)'(occupancy) + add_w - pop_w;
        ovf_w  = (sum_w > BUF_W);
        occ_nx = ovf_w ? CW'(BUF_BITS) : sum_w[CW-1:0];
        free_w = BUF_W - (CW+1)'(occupancy);
        // Hysteresis: set below threshold, clear only once HYST_BITS of extra room exists.
        if (free_w < HI_SET) begin
            hi_thr_nx = 1'b1;
        end else if (free_w >= HI_CLR) begin
            hi_thr_nx = 1'b0;
        end
        if (free_w < LO_SET) begin
            lo_thr_nx = 1'b1;
        end else if (free_w >= LO_CLR) begin
            lo_thr_nx = 1'b0;
        end
        busy_nx = (state == RUN) ? flush_req : (state != DONE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= RUN;
            wait_cnt       <= '0;
            occupancy      <= '0;
            overflow_err   <= 1'b0;
            hi_thr         <= 1'b0;
            lo_thr         <= 1'b0;
            logb_almful_hi <= 1'b0;
            logb_almful_lo <= 1'b0;
            flush_busy     <= 1'b0;
            flush_done     <= 1'b0;
        end else begin
            occupancy      <= occ_nx;
            overflow_err   <= overflow_err | ovf_w;
            hi_thr         <= hi_thr_nx;
            lo_thr         <= lo_thr_nx;
            logb_almful_hi <= busy_nx | hi_thr_nx;
            logb_almful_lo <= busy_nx | lo_thr_nx;
            flush_busy     <= busy_nx;
            flush_done     <= 1'b0;
            case (state)
                RUN: begin
                    if (flush_req) begin
                        state    <= FL_WAIT;
                        wait_cnt <= CTW'(WAIT_CNT);
                    end
                end
                // Wait out data already in flight between almful and the logger inputs.
                FL_WAIT: begin
                    if (wait_cnt <= CTW'(1)) begin
                        state    <= FL_DRAIN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - CTW'(1);
                    end
                end
                FL_DRAIN: begin
                    if ((occupancy == '0) && (add_w == '0)) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule
